// File: rtl/register_read_stage.sv
// Register-read stage: reads operands from the architectural register file
// (with write-port bypass), issues data-memory reads for loads, and presents
// a registered bundle to execute. Owns the register file that the write stage
// updates through a dedicated port.
module register_read_stage #(
  parameter int NR = 4,
  parameter int W  = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_hold,
  input  logic [W-1:0] d_pc,
  input  logic [W-1:0] d_adjustment_value,
  input  logic [4:0]   d_destination_register,
  input  logic [4:0]   d_left_register,
  input  logic [4:0]   d_right_register,
  input  logic [4:0]   d_address_register,
  input  logic [3:0]   d_operation,
  input  logic [1:0]   d_adjustment_operation,
  input  logic         d_has_flushed,
  input  logic         d_is_reading_memory,
  input  logic         d_is_writing_memory,
  input  logic         wr_enable,
  input  logic [4:0]   wr_register,
  input  logic [W-1:0] wr_value,
  output logic         mem_read,
  output logic [W-1:0] mem_address,
  input  logic [W-1:0] mem_data,
  input  logic         mem_data_valid,
  output logic         x_valid,
  input  logic         out_hold,
  output logic [W-1:0] x_pc,
  output logic [W-1:0] x_adjustment_value,
  output logic [W-1:0] x_left_value,
  output logic [W-1:0] x_right_value,
  output logic [4:0]   x_destination_register,
  output logic [4:0]   x_address_register,
  output logic [3:0]   x_operation,
  output logic [1:0]   x_adjustment_operation,
  output logic         x_has_flushed,
  output logic         x_is_writing_memory
);

  localparam int         IW     = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [4:0] PC_IDX = 5'(NR - 2);

  typedef enum logic [1:0] {ACCEPT, LOAD_WAIT, LOAD_READY} state_t;

  state_t       state, next_state;
  logic [W-1:0] rf [NR];

  logic         free, load_new, start_load, data_arrive, load_cap, wr_ok;
  logic [W-1:0] left_op, right_op, addr_op, load_right;

  // Load bundle captured at accept; operands are frozen from this point on.
  logic [W-1:0] cap_pc_p1, cap_adj_p1, cap_left_p1, cap_right_p1;
  logic [4:0]   cap_dst_p1, cap_areg_p1;
  logic [3:0]   cap_op_p1;
  logic [1:0]   cap_aop_p1;
  logic         cap_wm_p1;

  // Index 0 and out-of-range indices read as zero, PC reads the decode PC,
  // everything else reads storage with the in-flight write bypassed in.
  function automatic logic [W-1:0] read_operand(
    input logic [4:0]   idx,
    input logic [W-1:0] pc,
    input logic [W-1:0] stored,
    input logic         byp_en,
    input logic [4:0]   byp_idx,
    input logic [W-1:0] byp_val
  );
    logic [W-1:0] r;
    if (idx == 5'd0)                          r = '0;
    else if (idx == PC_IDX)                   r = pc;
    else if ({27'd0, idx} >= 32'(NR))         r = '0;
    else if (byp_en && (byp_idx == idx))      r = byp_val;
    else                                      r = stored;
    return r;
  endfunction

  assign left_op  = read_operand(d_left_register, d_pc, rf[d_left_register[IW-1:0]],
                                 wr_enable, wr_register, wr_value);
  assign right_op = read_operand(d_right_register, d_pc, rf[d_right_register[IW-1:0]],
                                 wr_enable, wr_register, wr_value);
  assign addr_op  = read_operand(d_address_register, d_pc, rf[d_address_register[IW-1:0]],
                                 wr_enable, wr_register, wr_value);

  assign free  = !(x_valid && out_hold);
  assign wr_ok = wr_enable && (wr_register != 5'd0) && (wr_register != PC_IDX)
                 && ({27'd0, wr_register} < 32'(NR));
  // Data arriving this cycle goes straight to the output when the slot is free.
  assign load_right = data_arrive ? mem_data : cap_right_p1;

  // Next-state and handshake decode for the accept / load sequencing.
  always_comb begin
    next_state  = state;
    in_hold     = 1'b1;
    load_new    = 1'b0;
    start_load  = 1'b0;
    data_arrive = 1'b0;
    load_cap    = 1'b0;
    case (state)
      ACCEPT: begin
        in_hold = !free;
        if (in_valid && free) begin
          if (d_is_reading_memory && !d_has_flushed) begin
            start_load = 1'b1;
            next_state = LOAD_WAIT;
          end else begin
            load_new = 1'b1;
          end
        end
      end
      LOAD_WAIT: begin
        if (mem_data_valid) begin
          data_arrive = 1'b1;
          if (free) begin
            load_cap   = 1'b1;
            next_state = ACCEPT;
          end else begin
            next_state = LOAD_READY;
          end
        end
      end
      LOAD_READY: begin
        if (free) begin
          load_cap   = 1'b1;
          next_state = ACCEPT;
        end
      end
      default: next_state = ACCEPT;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ACCEPT;
    else          state <= next_state;
  end

  // Register file write port; index 0, PC and out-of-range writes are dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NR; i++) rf[i] <= '0;
    end else if (wr_ok) begin
      rf[wr_register[IW-1:0]] <= wr_value;
    end
  end

  // Stage p1: load capture and memory request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_read     <= 1'b0;
      mem_address  <= '0;
      cap_pc_p1    <= '0;
      cap_adj_p1   <= '0;
      cap_left_p1  <= '0;
      cap_right_p1 <= '0;
      cap_dst_p1   <= '0;
      cap_areg_p1  <= '0;
      cap_op_p1    <= '0;
      cap_aop_p1   <= '0;
      cap_wm_p1    <= 1'b0;
    end else begin
      if (start_load) begin
        mem_read    <= 1'b1;
        mem_address <= addr_op;
        cap_pc_p1   <= d_pc;
        cap_adj_p1  <= d_adjustment_value;
        cap_left_p1 <= left_op;
        cap_dst_p1  <= d_destination_register;
        cap_areg_p1 <= d_address_register;
        cap_op_p1   <= d_operation;
        cap_aop_p1  <= d_adjustment_operation;
        cap_wm_p1   <= d_is_writing_memory;
      end
      if (data_arrive) begin
        mem_read     <= 1'b0;
        cap_right_p1 <= mem_data;
      end
    end
  end

  // Stage p2: output bundle to execute, held while execute stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_valid                <= 1'b0;
      x_pc                   <= '0;
      x_adjustment_value     <= '0;
      x_left_value           <= '0;
      x_right_value          <= '0;
      x_destination_register <= '0;
      x_address_register     <= '0;
      x_operation            <= '0;
      x_adjustment_operation <= '0;
      x_has_flushed          <= 1'b0;
      x_is_writing_memory    <= 1'b0;
    end else if (load_new) begin
      x_valid                <= 1'b1;
      x_pc                   <= d_pc;
      x_adjustment_value     <= d_adjustment_value;
      x_left_value           <= left_op;
      x_right_value          <= right_op;
      x_destination_register <= d_destination_register;
      x_address_register     <= d_address_register;
      x_operation            <= d_operation;
      x_adjustment_operation <= d_adjustment_operation;
      x_has_flushed          <= d_has_flushed;
      x_is_writing_memory    <= d_is_writing_memory && !d_has_flushed;
    end else if (load_cap) begin
      x_valid                <= 1'b1;
      x_pc                   <= cap_pc_p1;
      x_adjustment_value     <= cap_adj_p1;
      x_left_value           <= cap_left_p1;
      x_right_value          <= load_right;
      x_destination_register <= cap_dst_p1;
      x_address_register     <= cap_areg_p1;
      x_operation            <= cap_op_p1;
      x_adjustment_operation <= cap_aop_p1;
      x_has_flushed          <= 1'b0;
      x_is_writing_memory    <= cap_wm_p1;
    end else if (free) begin
      x_valid <= 1'b0;
    end
  end

endmodule

// File: doc/register_read_stage.md
# register_read_stage

Pipeline stage between decode and execute. It takes decoded instructions over the decode-to-read fields and reads operands from the architectural register file. For loads it fetches the operand from data memory. It presents a registered bundle on the read-to-execute fields, and it owns the register file that the write stage updates through a dedicated write port.

## Interface
Parameters:
- NR, 4: number of architectural registers. Index 0 is zero, index NR-2 is PC, index NR-1 is Flags.
- W, 32: register/data width (regval_t).

Ports:
- clock  in  1  stage clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode has an instruction (i_flow_control is_valid).
- in_hold  out  1  stage cannot accept this cycle (i_flow_control hold).
- d_pc, d_adjustment_value  in  32 each  from decode.
- d_destination_register, d_left_register, d_right_register, d_address_register  in  5 each  register indices.
- d_operation  in  4; d_adjustment_operation  in  2.
- d_has_flushed, d_is_reading_memory, d_is_writing_memory  in  1 each.
- wr_enable  in  1  write stage commits a register.
- wr_register  in  5  index to write.
- wr_value  in  32  value to write.
- mem_read  out  1  load request, registered.
- mem_address  out  32  load address, registered.
- mem_data  in  32  load data.
- mem_data_valid  in  1  one-cycle pulse qualifying mem_data.
- x_valid  out  1  bundle valid to execute.
- out_hold  in  1  execute stalls.
- x_pc, x_adjustment_value, x_left_value, x_right_value  out  32 each.
- x_destination_register, x_address_register  out  5 each.
- x_operation  out  4; x_adjustment_operation  out  2.
- x_has_flushed, x_is_writing_memory  out  1 each.

## Operation
Register file:
- NR×32 storage. It is written at the clock edge when wr_enable=1 and 0 < wr_register < NR, except index PC.
- Writes to index 0, to index PC, or to an index ≥ NR are ignored.

Operand read (for the left, right and address indices):
- Index 0 returns 0.
- Index PC returns d_pc.
- An index ≥ NR returns 0.
- Any other index returns the stored value, with bypass: if wr_enable and wr_register equals the index, wr_value is returned.

Output slot:
- The output slot is free when !(x_valid && out_hold).
- When the slot is free and no new bundle is loaded, x_valid clears.

FSM states: ACCEPT, LOAD_WAIT, LOAD_READY.
- ACCEPT: in_hold = !free. On in_valid && free:
  - If d_is_reading_memory && !d_has_flushed: capture all fields and the left operand, set mem_address = address operand and mem_read = 1, then go to LOAD_WAIT. The output is not loaded.
  - Otherwise: load the output register with the read operands and set x_valid = 1.
  - A flushed instruction passes through with x_has_flushed = 1, x_is_writing_memory forced to 0, and no memory access.
- LOAD_WAIT:
  - in_hold = 1. mem_read and mem_address are held.
  - On mem_data_valid: clear mem_read and store mem_data as the right operand.
  - If free in that same cycle, load the output and go to ACCEPT; otherwise go to LOAD_READY.
- LOAD_READY: in_hold = 1. When free, load the output with the captured bundle and go to ACCEPT.

Other rules:
- mem_data_valid outside LOAD_WAIT is ignored.
- Register writes during LOAD_WAIT/LOAD_READY do not alter operands that were already captured.

Reset:
- All outputs are 0, the register file is 0, and the state is ACCEPT. in_hold is 0 because the slot is free.
- An asserted reset_n low mid-load aborts the load immediately. mem_read drops and no bundle is produced.

## Timing
- Non-load latency: accept at edge N, x_valid high after edge N. Throughput is 1 per cycle when out_hold = 0.
- Load: accept at edge N. mem_read/mem_address are valid after N. x_valid rises at the edge where mem_data_valid is sampled, provided the slot is free.
- in_hold is combinational from state, x_valid and out_hold. Decode must hold its fields stable while in_hold = 1 and in_valid = 1.
- The outputs hold their values while x_valid && out_hold.
- Register-file write and same-cycle read: the new value is returned through the bypass.

## Test plan
- Reset, then write r1 = 0x12345678, then issue left = 1, right = 2, d_pc = 0x100 -> next cycle x_valid = 1, x_left_value = 0x12345678, x_right_value = 0x100.
- Same cycle: wr_enable, r3 ← 0xF and read left = 3 -> x_left_value = 0xF. A write to r0 or r2 followed by a read -> 0 and d_pc respectively.
- Load with address_register = 1 (r1 = 0x40) -> mem_read = 1 and mem_address = 0x40 until a mem_data_valid pulse with 0xDEAD. Next cycle x_right_value = 0xDEAD. in_hold = 1 throughout.
- Hold out_hold = 1 with x_valid = 1 for 3 cycles -> outputs stable and in_hold = 1. Then release -> the queued instruction is accepted. A load completing during this hold enters LOAD_READY and emits when the hold is released.
- A flushed load (d_has_flushed = 1, d_is_reading_memory = 1) -> no mem_read, x_has_flushed = 1, x_is_writing_memory = 0.
- Assert reset_n low during LOAD_WAIT -> mem_read = 0 and x_valid = 0 immediately. A later mem_data_valid is ignored.
